eq_cmp_stream: RTL and testbench
================================

Name: eq_cmp_stream

Overview:
- Parametrised, registered successor to the 1-bit equality comparator.
- Compares two W-bit operand streams under a bit mask with valid/ready flow control, and produces registered eq/gt/lt flags.
- Keeps saturating match and mismatch statistics, a sticky error flag, and a consecutive-match run detector.
- Sits between a data source and a checker/scoreboard stage in self-test datapaths.

Parameters:
- W, 8, operand width in bits (≥1).
- CNT_W, 16, width of the match/mismatch counters (≥2).
- RUN_LEN, 4, number of consecutive equal samples that fire run_hit (2..2^CNT_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of counters, run state and sticky_err.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- mask  in  W  per-bit compare enable (1 = compare bit).
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- eq  out  1  (a&mask)==(b&mask).
- gt  out  1  (a&mask)>(b&mask), unsigned.
- lt  out  1  (a&mask)<(b&mask), unsigned.
- run_hit  out  1  this result completes RUN_LEN consecutive equal samples.
- match_cnt  out  CNT_W  accepted equal samples, saturating.
- mismatch_cnt  out  CNT_W  accepted unequal samples, saturating.
- sticky_err  out  1  set on any mismatch, held until clr/reset.

Behaviour:
- Reset (reset_n=0, asynchronous): out_valid, eq, gt, lt, run_hit, sticky_err = 0; match_cnt, mismatch_cnt, run counter = 0. in_ready=1 immediately after reset release.
- in_ready = ~out_valid | out_ready (combinational). Accept = in_valid & in_ready.
- Latency: on accept at edge N, result flags are valid at edge N+1 (out_valid=1).
- Result register holds eq/gt/lt/run_hit stable while out_valid & ~out_ready.
- No accept & out_ready: out_valid clears next cycle; eq/gt/lt/run_hit clear with it.
- Accept & out_ready in the same cycle: back-to-back throughput of 1 sample/cycle.
- Exactly one of eq/gt/lt is 1 whenever out_valid=1.
- mask all-zero: eq=1.
- Statistics update on accept, computed from the accepted operands:
  - eq sample: match_cnt+1, saturating at 2^CNT_W-1.
  - mismatch sample: mismatch_cnt+1 (saturating), sticky_err←1.
- Run counter (internal, CNT_W bits):
  - Increments on each equal accept; mismatch resets it to 0.
  - When an equal accept brings it to RUN_LEN, that result carries run_hit=1 and the counter resets to 0 (non-overlapping detection).
- clr, synchronous, priority over statistics:
  - Zeroes counters, run counter and sticky_err.
  - Counter updates from an accept in the same cycle are discarded; that accept's eq/gt/lt are still registered, with run_hit=0.
  - clr does not affect out_valid or the handshake.
- reset_n asserted mid-stream: the in-flight result is dropped; no out_valid after release until a new accept.
- Operands are sampled only on accept; a/b/mask may change freely otherwise.

Optional Feature:
- EQ_CMP_SIGNED_EN defined: gt/lt use two's-complement signed comparison of the masked operands. eq is unaffected.
- Undefined: gt/lt are unsigned.
- Counters, run detection and handshake are identical in both builds.

Test Plan:
- Reset then single pair a=8'h5A, b=8'h5A, mask=8'hFF -> one cycle later out_valid=1, eq=1, gt=lt=0; match_cnt=1, mismatch_cnt=0, sticky_err=0.
- a=8'h0F, b=8'h03, mask=8'hFC -> eq=0, gt=1; mismatch_cnt=1, sticky_err=1 held through 10 further equal samples. With EQ_CMP_SIGNED_EN, a=8'h80, b=8'h01, mask=8'hFF -> lt=1 (unsigned build: gt=1).
- Stream of 9 equal pairs at full rate, out_ready=1, RUN_LEN=4 -> run_hit on results 4 and 8 only; match_cnt=9. Insert a mismatch at sample 3 of a second run -> run restarts, next run_hit 4 equal samples later.
- out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after first accept, result held stable, counters advance by exactly 1. Then out_ready=1 -> one result per cycle resumes, no loss or duplication.
- CNT_W=2, 5 mismatches -> mismatch_cnt saturates at 3. clr coincident with an equal accept -> counters=0, result eq=1, run_hit=0.
- reset_n pulsed low while out_valid=1 and out_ready=0 -> all outputs 0 asynchronously. After release, out_valid stays 0 until in_valid.

Source files
------------

// File: rtl/eq_cmp_stream.sv
// Masked W-bit equality/magnitude comparator stream with saturating match statistics and a run detector.
// Latency: 1 cycle from accept to registered eq/gt/lt/run_hit (out_valid). Throughput: 1 sample/cycle.
// Backpressure: in_ready = ~out_valid | out_ready; the result is held while out_valid & ~out_ready.
// Build option: define EQ_CMP_SIGNED_EN for two's-complement gt/lt; unsigned when undefined.
module eq_cmp_stream #(
    parameter int W       = 8,
    parameter int CNT_W   = 16,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             run_hit,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             sticky_err
);

    // Run counter value that, on one more equal sample, completes a run.
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [W-1:0]     ma;
    logic [W-1:0]     mb;
    logic             c_eq;
    logic             c_gt;
    logic             c_lt;
    logic             accept;
    logic             run_done;
    logic [CNT_W-1:0] run_cnt;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Masked compare of the current operands; only used when they are accepted.
    always_comb begin
        ma   = a & mask;
        mb   = b & mask;
        c_eq = (ma == mb);
`ifdef EQ_CMP_SIGNED_EN
        c_gt = ($signed(ma) > $signed(mb));
        c_lt = ($signed(ma) < $signed(mb));
`else
        c_gt = (ma > mb);
        c_lt = (ma < mb);
`endif
        // An equal sample that lands on the last run slot completes a run.
        run_done = c_eq & (run_cnt == RUN_LAST);
    end

    // Result register: load on accept, drop when consumed with nothing new behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            run_hit   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            eq        <= c_eq;
            gt        <= c_gt;
            lt        <= c_lt;
            // A clear in the same cycle discards run progress, so no hit is reported.
            run_hit   <= run_done & ~clr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            run_hit   <= 1'b0;
        end
    end

    // Statistics and run tracking; clr wins over any same-cycle accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            run_cnt      <= '0;
            sticky_err   <= 1'b0;
        end else if (clr) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            run_cnt      <= '0;
            sticky_err   <= 1'b0;
        end else if (accept) begin
            if (c_eq) begin
                if (match_cnt != CNT_MAX) begin
                    match_cnt <= match_cnt + 1'b1;
                end
                // Non-overlapping runs: restart counting after each hit.
                run_cnt <= run_done ? '0 : run_cnt + 1'b1;
            end else begin
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                run_cnt    <= '0;
                sticky_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eq_cmp_stream.sv
// Bench for eq_cmp_stream: a default instance (CNT_W=16, RUN_LEN=4) and a narrow one (CNT_W=2, RUN_LEN=3)
// share stimulus; expected results are queued on accept and compared when the DUT presents them.
// Honours EQ_CMP_SIGNED_EN for the gt/lt expectations.
module tb_eq_cmp_stream;

    localparam int RL1  = 4;
    localparam int RL2  = 3;
    localparam int MAX1 = 65535;
    localparam int MAX2 = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  mask;

    logic        in_ready1, out_valid1, eq1, gt1, lt1, hit1, st1;
    logic [15:0] mc1, mm1;
    logic        in_ready2, out_valid2, eq2, gt2, lt2, hit2, st2;
    logic [1:0]  mc2, mm2;

    always #5 clk = ~clk;

    eq_cmp_stream #(.W(8), .CNT_W(16), .RUN_LEN(RL1)) u_dut (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .mask(mask),
        .out_valid(out_valid1), .out_ready(out_ready),
        .eq(eq1), .gt(gt1), .lt(lt1), .run_hit(hit1),
        .match_cnt(mc1), .mismatch_cnt(mm1), .sticky_err(st1)
    );

    eq_cmp_stream #(.W(8), .CNT_W(2), .RUN_LEN(RL2)) u_dut_narrow (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .mask(mask),
        .out_valid(out_valid2), .out_ready(out_ready),
        .eq(eq2), .gt(gt2), .lt(lt2), .run_hit(hit2),
        .match_cnt(mc2), .mismatch_cnt(mm2), .sticky_err(st2)
    );

    typedef struct packed {
        logic e;
        logic g;
        logic l;
        logic h1;
        logic h2;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic       e;
        logic       g;
        logic       l;
    } vec_t;

    res_t q[$];
    vec_t tv[8];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   hits  = 0;
    int   m_mc1, m_mm1, m_run1, m_mc2, m_mm2, m_run2;
    logic m_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_mc1 = 0; m_mm1 = 0; m_run1 = 0;
        m_mc2 = 0; m_mm2 = 0; m_run2 = 0;
        m_st  = 1'b0;
    endtask

    task automatic model_cmp(input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] mm,
                             output logic e, output logic g, output logic l);
        logic [7:0] x;
        logic [7:0] y;
        x = aa & mm;
        y = bb & mm;
        e = (x == y);
`ifdef EQ_CMP_SIGNED_EN
        g = ($signed(x) > $signed(y));
        l = ($signed(x) < $signed(y));
`else
        g = (x > y);
        l = (x < y);
`endif
    endtask

    // One clock cycle: drive inputs, check presented result and handshake, then counters after the edge.
    task automatic step(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] mm,
                        input logic rdy, input logic cl,
                        input logic use_exp, input logic xe, input logic xg, input logic xl);
        res_t r;
        logic acc, e, g, l;
        in_valid  = v;
        a         = aa;
        b         = bb;
        mask      = mm;
        out_ready = rdy;
        clr       = cl;
        #2;
        chk("out_valid", {31'd0, out_valid1}, {31'd0, q.size() != 0});
        chk("out_valid_narrow", {31'd0, out_valid2}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready1}, {31'd0, (q.size() == 0) || rdy});
        chk("in_ready_narrow", {31'd0, in_ready2}, {31'd0, (q.size() == 0) || rdy});
        acc = v && ((q.size() == 0) || rdy);
        if (q.size() != 0) begin
            r = q[0];
            chk("result_flags", {28'd0, eq1, gt1, lt1, hit1}, {28'd0, r.e, r.g, r.l, r.h1});
            chk("result_narrow", {29'd0, eq2, hit2, gt2 | lt2}, {29'd0, r.e, r.h2, r.g | r.l});
            if (rdy) begin
                if (r.h1) hits++;
                void'(q.pop_front());
            end
        end else begin
            chk("idle_flags", {28'd0, eq1, gt1, lt1, hit1}, 32'd0);
        end
        if (acc) begin
            if (use_exp) begin
                e = xe; g = xg; l = xl;
            end else begin
                model_cmp(aa, bb, mm, e, g, l);
            end
            r = '{e: e, g: g, l: l, h1: 1'b0, h2: 1'b0};
            if (!cl) begin
                if (e) begin
                    m_run1++;
                    if (m_run1 == RL1) begin r.h1 = 1'b1; m_run1 = 0; end
                    m_run2++;
                    if (m_run2 == RL2) begin r.h2 = 1'b1; m_run2 = 0; end
                    if (m_mc1 < MAX1) m_mc1++;
                    if (m_mc2 < MAX2) m_mc2++;
                end else begin
                    if (m_mm1 < MAX1) m_mm1++;
                    if (m_mm2 < MAX2) m_mm2++;
                    m_run1 = 0;
                    m_run2 = 0;
                    m_st   = 1'b1;
                end
            end
            q.push_back(r);
        end
        if (cl) model_zero();
        @(posedge clk);
        #1;
        chk("match_cnt", {16'd0, mc1}, m_mc1);
        chk("mismatch_cnt", {16'd0, mm1}, m_mm1);
        chk("sticky_err", {31'd0, st1}, {31'd0, m_st});
        chk("match_cnt_narrow", {30'd0, mc2}, m_mc2);
        chk("mismatch_cnt_narrow", {30'd0, mm2}, m_mm2);
        chk("sticky_err_narrow", {31'd0, st2}, {31'd0, m_st});
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic eqs(input logic [7:0] v, input logic rdy);
        step(1'b1, v, v, 8'hFF, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset: outputs must fall without any clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("rst_flags", {28'd0, eq1, gt1, lt1, hit1}, 32'd0);
        chk("rst_counters", {mc1, mm1}, 32'd0);
        chk("rst_sticky", {31'd0, st1}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready1}, 32'd1);
        chk("rst_narrow", {26'd0, out_valid2, eq2, mc2, mm2}, 32'd0);
        q.delete();
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; mask = 8'h00;

        tv[0] = '{a: 8'h0F, b: 8'h03, m: 8'hFC, e: 1'b0, g: 1'b1, l: 1'b0};
`ifdef EQ_CMP_SIGNED_EN
        tv[1] = '{a: 8'h80, b: 8'h01, m: 8'hFF, e: 1'b0, g: 1'b0, l: 1'b1};
        tv[6] = '{a: 8'h7F, b: 8'h80, m: 8'hFF, e: 1'b0, g: 1'b1, l: 1'b0};
`else
        tv[1] = '{a: 8'h80, b: 8'h01, m: 8'hFF, e: 1'b0, g: 1'b1, l: 1'b0};
        tv[6] = '{a: 8'h7F, b: 8'h80, m: 8'hFF, e: 1'b0, g: 1'b0, l: 1'b1};
`endif
        tv[2] = '{a: 8'h12, b: 8'h34, m: 8'hFF, e: 1'b0, g: 1'b0, l: 1'b1};
        tv[3] = '{a: 8'hA5, b: 8'h3C, m: 8'h00, e: 1'b1, g: 1'b0, l: 1'b0};
        tv[4] = '{a: 8'hF0, b: 8'h0F, m: 8'h0F, e: 1'b0, g: 1'b0, l: 1'b1};
        tv[5] = '{a: 8'hAA, b: 8'hAB, m: 8'hFE, e: 1'b1, g: 1'b0, l: 1'b0};
        tv[7] = '{a: 8'hC3, b: 8'hC3, m: 8'hFF, e: 1'b1, g: 1'b0, l: 1'b0};

        do_reset();

        // First pair after reset.
        step(1'b1, 8'h5A, 8'h5A, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk("first_match_cnt", {16'd0, mc1}, 32'd1);

        // Table vectors at full rate.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tv[i].a, tv[i].b, tv[i].m, 1'b1, 1'b0, 1'b1, tv[i].e, tv[i].g, tv[i].l);
        end
        idle();

        // Sticky error survives a stream of equal samples.
        for (int i = 0; i < 10; i++) eqs(8'(i * 7), 1'b1);
        idle();
        chk("sticky_held", {31'd0, st1}, 32'd1);

        // Run detection: 9 equal samples, hits expected on 4 and 8.
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        hits = 0;
        for (int i = 0; i < 9; i++) eqs(8'(i), 1'b1);
        idle();
        chk("run_hits_9", hits, 32'd2);
        chk("match_cnt_9", {16'd0, mc1}, 32'd9);

        // Mismatch at sample 3 restarts the run; a hit follows 4 equal samples later.
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        hits = 0;
        eqs(8'h11, 1'b1);
        eqs(8'h22, 1'b1);
        step(1'b1, 8'h33, 8'h34, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) eqs(8'(i), 1'b1);
        chk("run_no_early_hit", hits, 32'd0);
        eqs(8'h44, 1'b1);
        idle();
        chk("run_restart_hit", hits, 32'd1);

        // Backpressure: 5 cycles stalled with new operands offered, then full-rate drain.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(i * 3), 8'(i * 3 + (i % 2)), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(i + 9), 8'(20 - i), 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        idle();

        // Saturation of the narrow mismatch counter.
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        chk("mismatch_sat_narrow", {30'd0, mm2}, 32'd3);
        chk("mismatch_wide", {16'd0, mm1}, 32'd5);

        // clr coincident with an equal accept that would otherwise complete a run.
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) eqs(8'(i + 1), 1'b1);
        step(1'b1, 8'h33, 8'h33, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk("clr_match_cnt", {16'd0, mc1}, 32'd0);

        // Reset while a result is held under backpressure.
        step(1'b1, 8'h05, 8'h05, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("held_before_reset", {31'd0, out_valid1}, 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) idle();
        step(1'b1, 8'h09, 8'h08, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
